// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 memory arbiter: FSM encoding and
// timeout defaults.
package dcpu16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FBUS = 2'd1,
    ST_GBUS = 2'd2,
    ST_GAP  = 2'd3
  } marb_state_t;

  localparam int unsigned TMO_DEFAULT = 255;
  localparam int          CNT_W       = 8;

  // A rendezvous ends when every port is either idle or already acknowledged.
  function automatic logic release_ok(input logic f_stb, input logic f_ack,
                                      input logic g_stb, input logic g_ack);
    return ~(f_stb ^ f_ack) & ~(g_stb ^ g_ack);
  endfunction

endpackage

// File: rtl/dcpu16_marb.sv
// Two-port (F read/write, G read-only) arbiter onto a single memory master
// port, with per-access timeout and a sticky timeout flag.
module dcpu16_marb
  import dcpu16_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] f_adr,
  input  logic        f_stb,
  input  logic        f_wre,
  input  logic [15:0] f_dto,
  output logic [15:0] f_dti,
  output logic        f_ack,
  input  logic [15:0] g_adr,
  input  logic        g_stb,
  output logic [15:0] g_dti,
  output logic        g_ack,
  output logic [15:0] m_adr,
  output logic        m_stb,
  output logic        m_wre,
  output logic [15:0] m_dto,
  input  logic [15:0] m_dti,
  input  logic        m_ack,
  output logic        tmo
);

  localparam logic [CNT_W-1:0] TMO_LIM = TMO[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  marb_state_t      state;
  marb_state_t      state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             f_done;
  logic             g_done;
  logic             f_pend;
  logic             g_pend;
  logic             release_cyc;
  logic             in_bus;
  logic             hit_ack;
  logic             hit_tmo;
  logic             fin_f;
  logic             fin_g;
  logic             start_f;
  logic             start_g;

  always_comb begin
    f_pend      = f_stb & ~f_ack & ~f_done;
    g_pend      = g_stb & ~g_ack & ~g_done;
    release_cyc = release_ok(f_stb, f_ack, g_stb, g_ack);
    in_bus      = (state == ST_FBUS) || (state == ST_GBUS);
    cnt_inc     = tmo_cnt + CNT_ONE;
    // m_ack wins over a timeout that expires in the same cycle
    hit_ack     = in_bus & m_ack;
    hit_tmo     = in_bus & ~m_ack & (cnt_inc == TMO_LIM);
    fin_f       = (state == ST_FBUS) & (hit_ack | hit_tmo);
    fin_g       = (state == ST_GBUS) & (hit_ack | hit_tmo);
    start_f     = 1'b0;
    start_g     = 1'b0;
    state_next  = state;
    case (state)
      ST_IDLE: begin
        if (f_pend) begin
          state_next = ST_FBUS;
          start_f    = 1'b1;
        end else if (g_pend) begin
          state_next = ST_GBUS;
          start_g    = 1'b1;
        end
      end
      ST_FBUS, ST_GBUS: begin
        if (hit_ack | hit_tmo) state_next = ST_GAP;
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      m_adr   <= 16'h0000;
      m_stb   <= 1'b0;
      m_wre   <= 1'b0;
      m_dto   <= 16'h0000;
      tmo     <= 1'b0;
    end else begin
      state <= state_next;
      if (start_f) begin
        m_adr   <= f_adr;
        m_stb   <= 1'b1;
        m_wre   <= f_wre;
        m_dto   <= f_dto;
        tmo_cnt <= '0;
      end else if (start_g) begin
        m_adr   <= g_adr;
        m_stb   <= 1'b1;
        m_wre   <= 1'b0;
        m_dto   <= f_dto;
        tmo_cnt <= '0;
      end else if (in_bus) begin
        if (hit_ack | hit_tmo) begin
          m_stb <= 1'b0;
          m_wre <= 1'b0;
        end else begin
          tmo_cnt <= cnt_inc;
        end
      end
      if (hit_tmo) tmo <= 1'b1;
    end
  end

  // F port handshake: ack only raised while the master still requests
  always_ff @(posedge clk) begin
    if (!rst) begin
      f_ack  <= 1'b0;
      f_done <= 1'b0;
      f_dti  <= 16'h0000;
    end else if (fin_f) begin
      f_ack  <= f_stb;
      f_done <= f_stb;
      if (hit_tmo)    f_dti <= 16'hFFFF;
      else if (m_wre) f_dti <= 16'h0000;
      else            f_dti <= m_dti;
    end else if (release_cyc || !f_stb) begin
      f_ack  <= 1'b0;
      f_done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      g_ack  <= 1'b0;
      g_done <= 1'b0;
      g_dti  <= 16'h0000;
    end else if (fin_g) begin
      g_ack  <= g_stb;
      g_done <= g_stb;
      g_dti  <= hit_tmo ? 16'hFFFF : m_dti;
    end else if (release_cyc || !g_stb) begin
      g_ack  <= 1'b0;
      g_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcpu16_marb.sv
// Randomized and directed bench for dcpu16_marb against a transaction-level
// model of the arbitration and memory contents.
module tb_dcpu16_marb;

  localparam int TMO_TB = 4;

  logic        clk;
  logic        rst;
  logic [15:0] f_adr, f_dto, f_dti, g_adr, g_dti;
  logic        f_stb, f_wre, f_ack, g_stb, g_ack;
  logic [15:0] m_adr, m_dto, m_dti;
  logic        m_stb, m_wre, m_ack, tmo;

  int errors = 0;
  int checks = 0;

  // memory device seen by the DUT, and the bench's own expectation of memory
  logic [15:0] dev_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  bit          mem_en  = 1'b1;
  int          ack_dly = 1;
  int          stb_cnt = 0;

  dcpu16_marb #(.TMO(TMO_TB)) dut (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto),
    .f_dti(f_dti), .f_ack(f_ack),
    .g_adr(g_adr), .g_stb(g_stb), .g_dti(g_dti), .g_ack(g_ack),
    .m_adr(m_adr), .m_stb(m_stb), .m_wre(m_wre), .m_dto(m_dto),
    .m_dti(m_dti), .m_ack(m_ack), .tmo(tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : (a ^ 16'hA5A5);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'hA5A5);
  endfunction

  // memory answers on the (ack_dly+1)-th cycle of each m_stb window
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (m_stb) begin
          stb_cnt++;
          if (stb_cnt == ack_dly + 1) begin
            m_ack = 1'b1;
            m_dti = dev_rd(m_adr);
            if (m_wre) dev_mem[m_adr] = m_dto;
          end else begin
            m_ack = 1'b0;
          end
        end else begin
          stb_cnt = 0;
          m_ack   = 1'b0;
        end
      end
    end
  end

  // One rendezvous: raise the requested strobes, wait for acks, hold one more
  // cycle, then drop. Latencies count negedges after the strobes are driven.
  task automatic xact(input bit df, input bit dg, input bit fw,
                      input logic [15:0] fa, input logic [15:0] fd, input logic [15:0] ga,
                      output int fl, output int gl, output logic [15:0] fv, output logic [15:0] gv,
                      output logic f_hold, output logic f_after, output logic g_after,
                      output int wins, output int stb_cyc);
    int   n;
    logic prev;
    @(negedge clk);
    f_stb = df; f_wre = fw; f_adr = fa; f_dto = fd;
    g_stb = dg; g_adr = ga;
    fl = -1; gl = -1; fv = 16'h0; gv = 16'h0; f_hold = 1'b0;
    wins = 0; stb_cyc = 0; prev = m_stb; n = 0;
    while (((df && fl < 0) || (dg && gl < 0)) && n < 40) begin
      @(negedge clk);
      n++;
      if (m_stb && !prev) wins++;
      if (m_stb) stb_cyc++;
      prev = m_stb;
      if (df && fl < 0 && f_ack) begin fl = n; fv = f_dti; end
      if (dg && gl < 0 && g_ack) begin gl = n; gv = g_dti; f_hold = f_ack; end
    end
    @(negedge clk);
    f_after = f_ack; g_after = g_ack;
    f_stb = 1'b0; g_stb = 1'b0; f_wre = 1'b0;
    repeat (3) begin
      if (m_stb && !prev) wins++;
      if (m_stb) stb_cyc++;
      prev = m_stb;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({f_ack, g_ack, m_stb, m_wre, tmo} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {f_ack, g_ack, m_stb, m_wre, tmo}); end
    checks++; if ({m_adr, m_dto, f_dti, g_dti} !== 64'h0) begin errors++;
      $display("FAIL reset_data: got %h required 0", {m_adr, m_dto, f_dti, g_dti}); end
    rst = 1'b1;
  endtask

  task automatic test_f_read;
    int fl, gl, w, sc; logic [15:0] fv, gv; logic fh, fa, ga;
    ack_dly = 1;
    xact(1, 0, 0, 16'h0100, 16'h0, 16'h0, fl, gl, fv, gv, fh, fa, ga, w, sc);
    checks++; if (fv !== 16'hBEEF) begin errors++; $display("FAIL fread_data: got %h required BEEF", fv); end
    checks++; if (fl !== 3) begin errors++; $display("FAIL fread_latency: got %0d required 3", fl); end
    checks++; if (fa !== 1'b0) begin errors++; $display("FAIL fread_release: f_ack %b required 0", fa); end
    checks++; if (w !== 1 || sc !== 2) begin errors++;
      $display("FAIL fread_window: windows %0d stb_cycles %0d required 1 2", w, sc); end
  endtask

  task automatic test_write_then_g;
    int fl, gl, w, sc; logic [15:0] fv, gv; logic fh, fa, ga;
    ack_dly = 1;
    ref_mem[16'h0200] = 16'h1234;
    xact(1, 1, 1, 16'h0200, 16'h1234, 16'h0200, fl, gl, fv, gv, fh, fa, ga, w, sc);
    checks++; if (gv !== 16'h1234) begin errors++; $display("FAIL wg_gdata: got %h required 1234", gv); end
    checks++; if (fv !== 16'h0000) begin errors++; $display("FAIL wg_fdata: got %h required 0000", fv); end
    checks++; if (fl !== 3 || gl !== 7) begin errors++;
      $display("FAIL wg_latency: f %0d g %0d required 3 7", fl, gl); end
    checks++; if (fh !== 1'b1) begin errors++; $display("FAIL wg_fhold: f_ack at g_ack %b required 1", fh); end
    checks++; if ({fa, ga} !== 2'b00) begin errors++; $display("FAIL wg_release: acks %b required 00", {fa, ga}); end
    checks++; if (w !== 2) begin errors++; $display("FAIL wg_windows: got %0d required 2", w); end
  endtask

  task automatic test_timeout;
    int fl, gl, w, sc; logic [15:0] fv, gv; logic fh, fa, ga;
    @(negedge clk);
    mem_en = 1'b0; m_ack = 1'b0;
    xact(0, 1, 0, 16'h0, 16'h0, 16'h0300, fl, gl, fv, gv, fh, fa, ga, w, sc);
    checks++; if (gv !== 16'hFFFF) begin errors++; $display("FAIL tmo_data: got %h required FFFF", gv); end
    checks++; if (gl !== TMO_TB + 1 || sc !== TMO_TB) begin errors++;
      $display("FAIL tmo_timing: ack %0d stb_cycles %0d required %0d %0d", gl, sc, TMO_TB + 1, TMO_TB); end
    checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b required 1", tmo); end
    mem_en = 1'b1; ack_dly = 0;
    xact(0, 1, 0, 16'h0, 16'h0, 16'h0200, fl, gl, fv, gv, fh, fa, ga, w, sc);
    checks++; if (gv !== 16'h1234 || gl !== 2) begin errors++;
      $display("FAIL tmo_after_read: data %h lat %0d required 1234 2", gv, gl); end
    checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", tmo); end
  endtask

  task automatic test_reset_mid;
    int fl, gl, w, sc; logic [15:0] fv, gv; logic fh, fa, ga;
    @(negedge clk);
    mem_en = 1'b0; m_ack = 1'b0;
    f_stb = 1'b1; f_wre = 1'b0; f_adr = 16'h0100;
    repeat (2) @(negedge clk);
    checks++; if (m_stb !== 1'b1 || m_adr !== 16'h0100) begin errors++;
      $display("FAIL rstmid_busy: m_stb %b m_adr %h required 1 0100", m_stb, m_adr); end
    rst = 1'b0; f_stb = 1'b0;
    @(negedge clk);
    checks++; if ({f_ack, g_ack, m_stb, m_wre, tmo} !== 5'b0 || {m_adr, m_dto, f_dti, g_dti} !== 64'h0) begin
      errors++; $display("FAIL rstmid_outputs: ctrl %b data %h required all 0",
                         {f_ack, g_ack, m_stb, m_wre, tmo}, {m_adr, m_dto, f_dti, g_dti}); end
    rst = 1'b1; m_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({f_ack, m_stb, tmo} !== 3'b0) begin errors++;
        $display("FAIL rstmid_stale_ack: f_ack/m_stb/tmo %b required 000", {f_ack, m_stb, tmo}); end
    end
    m_ack = 1'b0; mem_en = 1'b1; ack_dly = 1;
    xact(1, 0, 0, 16'h0100, 16'h0, 16'h0, fl, gl, fv, gv, fh, fa, ga, w, sc);
    checks++; if (fv !== 16'hBEEF || fl !== 3) begin errors++;
      $display("FAIL rstmid_recover: data %h lat %0d required BEEF 3", fv, fl); end
  endtask

  task automatic test_stb_drop;
    int n;
    @(negedge clk);
    ack_dly = 1;
    f_stb = 1'b1; f_wre = 1'b0; f_adr = 16'h0400;
    n = 0;
    while (!f_ack && n < 20) begin @(negedge clk); n++; end
    checks++; if (f_ack !== 1'b1) begin errors++; $display("FAIL drop_ack_seen: got %b required 1", f_ack); end
    f_stb = 1'b0;
    @(negedge clk);
    checks++; if (f_ack !== 1'b0) begin errors++; $display("FAIL drop_ack_clear: got %b required 0", f_ack); end
    n = 0;
    repeat (5) begin @(negedge clk); if (m_stb) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL drop_no_access: stb cycles %0d required 0", n); end
  endtask

  task automatic test_back_to_back;
    int n, wins, gap, low_run;
    logic prev;
    logic [15:0] d0, d1;
    @(negedge clk);
    ack_dly = 1;
    f_stb = 1'b1; f_wre = 1'b0; f_adr = 16'hFFFF;
    n = 0; wins = 0; gap = -1; low_run = 0; prev = m_stb; d0 = 16'h0; d1 = 16'h0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!f_ack && n < 20) begin
        @(negedge clk); n++;
        if (m_stb && !prev) begin wins++; if (wins == 2) gap = low_run; end
        low_run = m_stb ? 0 : low_run + 1;
        prev = m_stb;
      end
      if (k == 0) d0 = f_dti; else d1 = f_dti;
      @(negedge clk);
      low_run = m_stb ? 0 : low_run + 1;
      prev = m_stb;
      if (k == 0) f_adr = 16'h0000; else f_stb = 1'b0;
    end
    checks++; if (d0 !== ref_rd(16'hFFFF) || d1 !== ref_rd(16'h0000)) begin errors++;
      $display("FAIL b2b_data: got %h %h required %h %h", d0, d1, ref_rd(16'hFFFF), ref_rd(16'h0000)); end
    checks++; if (wins !== 2 || gap !== 2) begin errors++;
      $display("FAIL b2b_windows: windows %0d gap %0d required 2 2", wins, gap); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    int op, d, fl, gl, w, sc, efl, egl;
    bit df, dg, fw;
    logic [15:0] fa, fd, ga, fv, gv, ef, eg;
    logic fh, fa_r, ga_r;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 3);
      d  = $urandom_range(0, 3);
      fa = 16'h0010 + 16'($urandom_range(0, 3));
      ga = 16'h0010 + 16'($urandom_range(0, 3));
      fd = 16'($urandom);
      df = (op != 2); dg = (op >= 2); fw = (op == 1) || (op == 3);
      ack_dly = d;
      ef = fw ? 16'h0000 : ref_rd(fa);
      if (df && fw) ref_mem[fa] = fd;
      eg  = ref_rd(ga);
      efl = df ? d + 2 : -1;
      egl = dg ? (df ? 2 * d + 5 : d + 2) : -1;
      xact(df, dg, fw, fa, fd, ga, fl, gl, fv, gv, fh, fa_r, ga_r, w, sc);
      checks++; if (fl !== efl || gl !== egl) begin errors++;
        $display("FAIL rnd%0d_latency: f %0d g %0d required %0d %0d", i, fl, gl, efl, egl); end
      if (df) begin checks++; if (fv !== ef) begin errors++;
        $display("FAIL rnd%0d_fdata: got %h required %h", i, fv, ef); end end
      if (dg) begin checks++; if (gv !== eg) begin errors++;
        $display("FAIL rnd%0d_gdata: got %h required %h", i, gv, eg); end end
      checks++; if ({fa_r, ga_r} !== 2'b00) begin errors++;
        $display("FAIL rnd%0d_release: acks %b required 00", i, {fa_r, ga_r}); end
      checks++; if (w !== int'(df) + int'(dg) || sc !== (int'(df) + int'(dg)) * (d + 1)) begin errors++;
        $display("FAIL rnd%0d_windows: windows %0d stb_cycles %0d required %0d %0d", i, w, sc,
                 int'(df) + int'(dg), (int'(df) + int'(dg)) * (d + 1)); end
    end
  endtask

  initial begin
    rst = 1'b0;
    f_adr = 16'h0; f_stb = 1'b0; f_wre = 1'b0; f_dto = 16'h0;
    g_adr = 16'h0; g_stb = 1'b0;
    m_dti = 16'h0; m_ack = 1'b0;
    dev_mem[16'h0100] = 16'hBEEF;
    ref_mem[16'h0100] = 16'hBEEF;
    test_reset();
    test_f_read();
    test_write_then_g();
    test_timeout();
    test_reset_mid();
    test_stb_drop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
